// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: opcode encodings and the
// opcode-support predicate used to raise rsp_err.
package alu_share_arbiter_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_LDA = 4'b0100;

  function automatic logic is_supported(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin first-valid finder.
// Ports:
//   vec_i    - request vector
//   ptr_i    - search start index (0 gives plain lowest-index priority)
//   onehot_o - one-hot of the first set bit at or after ptr_i, wrapping
//   idx_o    - binary index of that bit
//   any_o    - high when any bit of vec_i is set
module alu_share_arbiter_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     vec_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     onehot_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  logic found;

  // Two passes instead of a modulo index: first search [ptr, N-1], then, if
  // nothing was found, take the lowest set bit, which must lie below ptr.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && vec_i[j] && (j >= 32'(ptr_i))) begin
        found       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = PTR_W'(j);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && vec_i[j]) begin
        found       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = PTR_W'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters. One grant per cycle chosen by
// lock holder, then fixed priority or round-robin; the result is returned
// registered one cycle after the handshake.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   prio_mode   - 0 round-robin, 1 fixed priority (index 0 highest)
//   req_valid   - per-requester request valid
//   req_lock    - per-requester request to keep the grant next cycle
//   req_op      - per-requester 4-bit opcode slices
//   req_a/req_b - per-requester operand slices
//   req_ready   - combinational one-hot grant
//   rsp_valid   - registered one-hot result strobe
//   rsp_data    - registered shared result bus
//   rsp_err     - registered unsupported-opcode flag
//   lock_owner  - one-hot current lock holder (0 = none)
//   op_count    - saturating count of completed grants
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      prio_mode,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [4*NUM_REQ-1:0]      req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [NUM_REQ-1:0]        lock_owner,
  output logic [CNT_W-1:0]          op_count
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] lock_q, lock_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PTR_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_oh;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;

  logic               lock_hit;
  logic [PTR_W-1:0]   lock_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [PTR_W-1:0]   grant_idx;
  logic               hs;

  logic [3:0]         sel_op;
  logic [DATA_W-1:0]  sel_a, sel_b;
  logic [DATA_W-1:0]  alu_res;

  // Fixed priority is a round-robin search that always starts at index 0.
  assign pick_ptr = prio_mode ? '0 : rr_ptr_q;

  alu_share_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .vec_i    (req_valid),
    .ptr_i    (pick_ptr),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    lock_hit = |(lock_q & req_valid);
    lock_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (lock_q[i]) lock_idx = PTR_W'(i);
    end
    grant_oh  = lock_hit ? lock_q : pick_oh;
    grant_idx = lock_hit ? lock_idx : pick_idx;
    hs        = lock_hit | pick_any;
  end

  assign req_ready = grant_oh;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_op = req_op[4*i +: 4];
        sel_a  = req_a[DATA_W*i +: DATA_W];
        sel_b  = req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    alu_res = '0;
    case (sel_op)
      OP_ADD:  alu_res = sel_a + sel_b;
      OP_SUB:  alu_res = sel_a - sel_b;
      OP_AND:  alu_res = sel_a & sel_b;
      OP_LDA:  alu_res = sel_a + sel_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    rsp_valid_d = grant_oh;
    // Without a handshake no requester is valid, so any lock holder has
    // dropped its request and the lock is released.
    lock_d      = (hs && |(req_lock & grant_oh)) ? grant_oh : '0;
    if (hs) begin
      rr_ptr_d   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      rsp_data_d = alu_res;
      rsp_err_d  = !is_supported(sel_op);
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      lock_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign lock_owner = lock_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter with a response scoreboard.
module tb_alu_share_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           prio_mode;
  logic [NR-1:0]  req_valid, req_lock;
  logic [4*NR-1:0]  req_op;
  logic [DW*NR-1:0] req_a, req_b;
  logic [NR-1:0]  req_ready, rsp_valid, lock_owner;
  logic [DW-1:0]  rsp_data;
  logic           rsp_err;
  logic [CW-1:0]  op_count;

  alu_share_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .prio_mode  (prio_mode),
    .req_valid  (req_valid),
    .req_lock   (req_lock),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .lock_owner (lock_owner),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] oh;
    logic [DW-1:0] data;
    logic          err;
    int unsigned   due;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;

  // Default per-requester operands and their hand-computed results:
  // r0 ADD 10+01=11, r1 SUB 20-01=1F, r2 AND F0&3C=30, r3 LDA 40+02=42.
  logic [DW-1:0] exp_d [NR] = '{8'h11, 8'h1F, 8'h30, 8'h42};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic [3:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_op[4*i +: 4]   = op;
    req_a[DW*i +: DW]  = a;
    req_b[DW*i +: DW]  = b;
  endtask

  task automatic load_defaults();
    set_req(0, 4'b0001, 8'h10, 8'h01);
    set_req(1, 4'b0010, 8'h20, 8'h01);
    set_req(2, 4'b0011, 8'hF0, 8'h3C);
    set_req(3, 4'b0100, 8'h40, 8'h02);
  endtask

  // Present one cycle of requests, check the combinational grant and queue
  // the response expected one cycle later.
  task automatic cycle(input logic [NR-1:0] v, input logic [NR-1:0] l,
                       input logic [NR-1:0] exp_rdy, input logic [DW-1:0] exp_data,
                       input logic exp_err);
    exp_t x;
    @(posedge clk);
    #1;
    req_valid = v;
    req_lock  = l;
    #1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != '0) begin
      x.oh   = exp_rdy;
      x.data = exp_data;
      x.err  = exp_err;
      x.due  = cyc + 1;
      sbq.push_back(x);
    end
  endtask

  task automatic idle();
    cycle('0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = '0;
    req_lock  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  // Monitor: every presented response must match the head of the queue.
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (sbq.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        e = sbq.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(e.oh));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_latency", cyc, e.due);
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      check("rsp_missing", 32'(rsp_valid), 32'(e.oh));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    prio_mode = 1'b0;
    req_valid = '0;
    req_lock  = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    load_defaults();
    set_req(0, 4'b0001, 8'h05, 8'h03);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_data", 32'(rsp_data), 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'h0);
    check("reset_lock_owner", 32'(lock_owner), 32'h0);
    check("reset_op_count", 32'(op_count), 32'h0);

    // Single ADD from requester 0.
    cycle(4'b0001, 4'b0000, 4'b0001, 8'h08, 1'b0);
    idle();
    check("op_count_single", 32'(op_count), 32'd1);

    // Round-robin with all requesters valid, pointer restarted at 0.
    do_reset();
    load_defaults();
    check("op_count_after_reset", 32'(op_count), 32'd0);
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1111, 4'b0000, 4'(1 << (k % 4)), exp_d[k % 4], 1'b0);
    end
    idle();
    check("op_count_rr", 32'(op_count), 32'd8);

    // Fixed priority starves requesters 2 and 3.
    prio_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(4'b1110, 4'b0000, 4'b0010, 8'h1F, 1'b0);
    end
    idle();
    prio_mode = 1'b0;
    check("op_count_prio", 32'(op_count), 32'd11);

    // Lock by requester 2, then release by dropping valid; pointer is 3.
    cycle(4'b0100, 4'b0100, 4'b0100, 8'h30, 1'b0);
    cycle(4'b1111, 4'b0100, 4'b0100, 8'h30, 1'b0);
    check("lock_owner_1", 32'(lock_owner), 32'b0100);
    cycle(4'b1111, 4'b0100, 4'b0100, 8'h30, 1'b0);
    check("lock_owner_2", 32'(lock_owner), 32'b0100);
    cycle(4'b1011, 4'b0000, 4'b1000, 8'h42, 1'b0);
    check("lock_owner_3", 32'(lock_owner), 32'b0100);
    idle();
    check("lock_released", 32'(lock_owner), 32'h0);
    check("op_count_lock", 32'(op_count), 32'd15);

    // SUB wrap, then unsupported opcode.
    set_req(0, 4'b0010, 8'h00, 8'h01);
    cycle(4'b0001, 4'b0000, 4'b0001, 8'hFF, 1'b0);
    idle();
    set_req(0, 4'b1111, 8'h12, 8'h34);
    cycle(4'b0001, 4'b0000, 4'b0001, 8'h00, 1'b1);
    idle();
    check("err_held", 32'(rsp_err), 32'h1);
    check("data_held", 32'(rsp_data), 32'h0);
    check("op_count_err", 32'(op_count), 32'd17);
    load_defaults();

    // Reset coinciding with a handshake discards it.
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = 4'b0001;
    @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("pending_rsp_valid", 32'(rsp_valid), 32'h0);
    check("pending_op_count", 32'(op_count), 32'h0);
    cycle(4'b1111, 4'b0000, 4'b0001, 8'h11, 1'b0);

    // Counter saturation: 36 grants into a 5-bit counter.
    for (int k = 0; k < 35; k++) begin
      cycle(4'b1111, 4'b0000, 4'(1 << ((k + 1) % 4)), exp_d[(k + 1) % 4], 1'b0);
    end
    idle();
    check("op_count_sat", 32'(op_count), 32'd31);

    idle();
    idle();
    check("scoreboard_drained", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 8-bit ALU between NUM_REQ independent requesters, e.g. pipeline EX stage, address-generation unit and debug/DMA port.
- Grants at most one request per cycle using round-robin or fixed priority, with optional lock for back-to-back sequences.
- Returns a registered result to the granted requester one cycle later.
- Sits between the requesters and the ALU; owns all ALU operand muxing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand/result width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (index 0 highest)
- req_valid  in  NUM_REQ  per-requester request valid
- req_lock  in  NUM_REQ  requester asks to keep the grant next cycle
- req_op  in  4*NUM_REQ  per-requester opcode, slice i = [4i+3:4i]
- req_a  in  DATA_W*NUM_REQ  operand A slices
- req_b  in  DATA_W*NUM_REQ  operand B slices
- req_ready  out  NUM_REQ  one-hot grant, combinational, this cycle
- rsp_valid  out  NUM_REQ  one-hot, registered result strobe
- rsp_data  out  DATA_W  registered result, shared bus
- rsp_err  out  1  registered; high with rsp_valid when opcode was unsupported
- lock_owner  out  NUM_REQ  one-hot current lock holder, 0 = none
- op_count  out  CNT_W  completed grants, saturating

Behaviour:
- Opcodes: 0001 ADD, 0010 SUB, 0011 AND, 0100 LOADADDR (A+B). All others produce result 0 and rsp_err=1. Arithmetic is modulo 2^DATA_W; carry and borrow are dropped.
- Grant selection is combinational from req_valid, the pointer and lock state:
  - If lock_owner != 0 and that requester's req_valid=1, grant it.
  - Otherwise, prio_mode=1 grants the lowest valid index.
  - Otherwise (prio_mode=0), grant the first valid index at or after rr_ptr, wrapping NUM_REQ-1 to 0.
- req_ready is nonzero only when some req_valid=1. A handshake occurs when req_valid[i] and req_ready[i] are both high.
- On handshake g:
  - rr_ptr <= (g+1) mod NUM_REQ. rr_ptr is also updated in fixed mode so that switching modes is seamless.
  - ALU operands come from slice g. The result is registered: rsp_valid <= onehot(g), rsp_data <= result, rsp_err <= unsupported(op).
  - op_count increments, saturating at all-ones.
- No handshake: rsp_valid <= 0; rsp_data and rsp_err hold their values.
- Latency is exactly 1 cycle from handshake to rsp_valid. Throughput is 1 op/cycle. There is no response back-pressure.
- Lock handling:
  - On handshake g with req_lock[g]=1: lock_owner <= onehot(g).
  - On handshake g with req_lock[g]=0: lock_owner <= 0.
  - If the lock holder drops req_valid: lock_owner <= 0 that cycle, and arbitration proceeds normally in the same cycle.
  - The lock overrides prio_mode.
- Reset: rr_ptr=0, lock_owner=0, rsp_valid=0, rsp_data=0, rsp_err=0, op_count=0. A response pending at reset is discarded; no rsp_valid follows reset.
- Simultaneous requests from all requesters in RR mode: every requester is served once per NUM_REQ cycles.
- prio_mode is sampled every cycle. A change takes effect in the same cycle's arbitration.

Decomposition:
- Shared package holds:
  - Opcode localparams OP_ADD=4'b0001, OP_SUB=4'b0010, OP_AND=4'b0011, OP_LDA=4'b0100.
  - Function is_supported(op).
- One sub-module, rr_pick: combinational round-robin first-valid finder (inputs vector and pointer; outputs one-hot and index).
- The ALU evaluation stays inline: a single case on the selected opcode.

Test Plan:
- Reset, then req_valid=0001, op=ADD, a=8'h05, b=8'h03 -> req_ready=0001 that cycle; next cycle rsp_valid=0001, rsp_data=8'h08, rsp_err=0, op_count=1.
- RR mode, req_valid=1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3; op_count=8.
- prio_mode=1, req_valid=1110 for 3 cycles -> req_ready=0010 every cycle; requesters 2 and 3 starved.
- Lock: requester 2 with req_lock=1 for 3 cycles, others valid -> grants 2,2,2 and lock_owner=0100. Requester 2 then drops req_valid -> lock_owner=0, and requester 3 (ptr=3) is granted the same cycle.
- Wrap and error: SUB a=8'h00, b=8'h01 -> 8'hFF. op=4'b1111 -> rsp_data=0, rsp_err=1, counted.
- Reset asserted the cycle after a handshake -> rsp_valid stays 0; op_count=0; next grant starts from index 0.
